riscv_bitops_seq: RTL and testbench
===================================

Name: riscv_bitops_seq

Overview:
Iterative, multi-cycle execution engine for the custom bit-operation instructions in the EX stage. It is the issuing and result-returning counterpart of the bitops operator interface. It accepts enable/operator/operand from the EX stage and scans the operand BITS_PER_CYCLE bits per cycle, LSB first. It returns a 32-bit result with a ready_o handshake in the same style as the multiplier.

Parameters:
BITS_PER_CYCLE, 4, operand bits consumed per RUN cycle; legal values 1, 2, 4, 8.
NUM_ITER, 32/BITS_PER_CYCLE, derived localparam; number of RUN cycles.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
enable_i  in  1  bitops instruction present in EX; held high until retired
operator_i  in  BIT_OP_WIDTH  operation select (BOP_* codes)
operand_i  in  32  source operand (rs1)
ex_ready_i  in  1  downstream can accept the result this cycle
result_o  out  32  operation result; valid while ready_o=1 in DONE
ready_o  out  1  unit can advance (idle and not starting, or result available)

Behaviour:
- Operations (riscv_defines, BIT_OP_WIDTH=3):
  - BOP_CNT=000: popcount, 0..32.
  - BOP_FF1=001: index of lowest set bit; 32 if operand is 0.
  - BOP_FL1=010: index of highest set bit; 32 if operand is 0.
  - BOP_REV=011: bit reverse.
  - BOP_PAR=100: XOR of all bits in result[0]; upper bits 0.
  - Codes 101-111: result 0, same latency.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready_o = !enable_i.
  - On enable_i: latch operator_i into op_q and operand_i into shreg_q; clear acc_q, found_q, iter_q; go to RUN.
- RUN:
  - ready_o=0.
  - Each cycle, process chunk = shreg_q[BITS_PER_CYCLE-1:0] at base index iter_q*BITS_PER_CYCLE.
  - Shift shreg_q right by BITS_PER_CYCLE; iter_q++.
  - When iter_q==NUM_ITER-1, go to DONE.
- Per-op accumulation:
  - CNT: acc += popcount(chunk).
  - FF1: if !found_q and chunk!=0, then acc = base + lowest set index in chunk; found_q=1.
  - FL1: if chunk!=0, then acc = base + highest set index in chunk; found_q=1.
  - REV: acc = {acc[31-BITS_PER_CYCLE:0], bitreverse(chunk)}.
  - PAR: acc[0] ^= ^chunk.
- Entering DONE: for FF1/FL1 with found_q=0 after the final chunk, acc=32.
- DONE:
  - ready_o=1; result_o=acc_q.
  - If ex_ready_i, go to IDLE; otherwise hold with result_o stable.
  - enable_i in DONE belongs to the retiring instruction and never starts a new op. The next op is accepted in IDLE at the earliest one cycle later.
- Latency: enable_i sampled in IDLE at cycle 0; ready_o=1 at cycle NUM_ITER+1 (9 for BITS_PER_CYCLE=4).
- result_o is 0 in IDLE and RUN; it equals acc_q only in DONE.
- operator_i/operand_i changes during RUN or DONE are ignored (latched copies are used).
- Reset, asynchronous, any state including mid-RUN:
  - State goes to IDLE.
  - acc_q, shreg_q, op_q, iter_q, found_q are cleared.
  - result_o=0.
  - ready_o=1 while enable_i=0.
- iter_q width is $clog2(NUM_ITER), with minimum 1; no wrap beyond NUM_ITER-1.
- acc_q is 32 bits wide. Counts never exceed 32, so there is no overflow.

Decomposition:
- riscv_defines holds BIT_OP_WIDTH and the BOP_CNT/FF1/FL1/REV/PAR constants. It also holds the bitops FSM state enum, bitops_state_e {BOP_IDLE, BOP_RUN, BOP_DONE}.
- One combinational sub-module, riscv_bitops_chunk:
  - Parameter BITS_PER_CYCLE.
  - Input: chunk.
  - Outputs: popcount, lowest-set index, highest-set index, nonzero flag, reversed chunk, parity.
- The top level holds the FSM, iteration counter, shift register and accumulators.

Test Plan:
1. BITS_PER_CYCLE=4, BOP_CNT, operand 0xF0F0_0001, ex_ready_i=1 -> ready_o=0 for cycles 1..8; ready_o=1 with result_o=9 at cycle 9; IDLE at cycle 10.
2. BOP_FF1 operand 0x0000_0100 -> 8. BOP_FF1 operand 0 -> 32. BOP_FL1 operand 0x8000_0001 -> 31. BOP_FL1 operand 0 -> 32.
3. BOP_REV operand 0x0000_0001 -> 0x8000_0000. BOP_REV operand 0x1234_5678 -> 0x1E6A_2C48. BOP_PAR operand 0x0000_0007 -> 1.
4. Stall: BOP_CNT operand 0xFFFF_FFFF with ex_ready_i=0 for 3 cycles in DONE -> result_o=32 and ready_o=1 held stable. Operand_i changed during the stall has no effect. Returns to IDLE the cycle after ex_ready_i=1.
5. Reset mid-op: assert rst_n=0 at RUN cycle 4 -> next-cycle state IDLE, result_o=0, ready_o=1 with enable_i=0. A new BOP_CNT 0x3 then completes normally with result 2.
6. Sweep BITS_PER_CYCLE in {1,2,8} with BOP_FL1 operand 0x0001_0000 -> result 16 at latency 33, 17 and 5 respectively. Unused code 3'b111 -> result 0 at the same latency.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared constants for the bit-operation unit: operator codes and FSM state encoding.
package riscv_defines;

  localparam int BIT_OP_WIDTH = 3;

  localparam logic [BIT_OP_WIDTH-1:0] BOP_CNT = 3'b000;
  localparam logic [BIT_OP_WIDTH-1:0] BOP_FF1 = 3'b001;
  localparam logic [BIT_OP_WIDTH-1:0] BOP_FL1 = 3'b010;
  localparam logic [BIT_OP_WIDTH-1:0] BOP_REV = 3'b011;
  localparam logic [BIT_OP_WIDTH-1:0] BOP_PAR = 3'b100;

  typedef enum logic [1:0] {
    BOP_IDLE,
    BOP_RUN,
    BOP_DONE
  } bitops_state_e;

endpackage

// File: rtl/riscv_bitops_seq_if.sv
// Issue/result handshake between the EX stage (master) and the bitops unit (slave).
interface riscv_bitops_seq_if;
  import riscv_defines::*;

  logic                    enable_i;
  logic [BIT_OP_WIDTH-1:0] operator_i;
  logic [31:0]             operand_i;
  logic                    ex_ready_i;
  logic [31:0]             result_o;
  logic                    ready_o;

  modport master (
    output enable_i, operator_i, operand_i, ex_ready_i,
    input  result_o, ready_o
  );

  modport slave (
    input  enable_i, operator_i, operand_i, ex_ready_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/riscv_bitops_chunk.sv
// Combinational per-chunk analysis: popcount, lowest/highest set index,
// nonzero flag, bit-reversed chunk and parity.
module riscv_bitops_chunk #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic [BITS_PER_CYCLE-1:0] chunk_i,
  output logic [3:0]                popcount_o,
  output logic [2:0]                low_idx_o,
  output logic [2:0]                high_idx_o,
  output logic                      nonzero_o,
  output logic [BITS_PER_CYCLE-1:0] rev_o,
  output logic                      parity_o
);

  always_comb begin
    popcount_o = '0;
    low_idx_o  = '0;
    high_idx_o = '0;
    rev_o      = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      popcount_o = popcount_o + 4'(chunk_i[i]);
      rev_o[i]   = chunk_i[BITS_PER_CYCLE-1-i];
    end
    // Scan downward so the lowest set bit is the last one written.
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      if (chunk_i[i]) low_idx_o = 3'(i);
    end
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (chunk_i[i]) high_idx_o = 3'(i);
    end
  end

  assign nonzero_o = |chunk_i;
  assign parity_o  = ^chunk_i;

endmodule

// File: rtl/riscv_bitops_seq.sv
// Iterative bit-operation engine: scans the latched operand LSB first,
// BITS_PER_CYCLE bits per cycle, and returns the result with a ready handshake.
module riscv_bitops_seq
  import riscv_defines::*;
#(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  riscv_bitops_seq_if.slave  bus
);

  localparam int NUM_ITER = 32 / BITS_PER_CYCLE;
  localparam int ITER_W   = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
  localparam int SHIFT    = $clog2(BITS_PER_CYCLE);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_ITER - 1);

  bitops_state_e           state_q, state_d;
  logic [BIT_OP_WIDTH-1:0] op_q, op_d;
  logic [31:0]             shreg_q, shreg_d;
  logic [31:0]             acc_q, acc_d;
  logic [ITER_W-1:0]       iter_q, iter_d;
  logic                    found_q, found_d;

  logic [3:0]                chunk_pop;
  logic [2:0]                chunk_low;
  logic [2:0]                chunk_high;
  logic                      chunk_nz;
  logic [BITS_PER_CYCLE-1:0] chunk_rev;
  logic                      chunk_par;
  logic [5:0]                base;
  logic                      last_iter;

  riscv_bitops_chunk #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_chunk (
    .chunk_i    (shreg_q[BITS_PER_CYCLE-1:0]),
    .popcount_o (chunk_pop),
    .low_idx_o  (chunk_low),
    .high_idx_o (chunk_high),
    .nonzero_o  (chunk_nz),
    .rev_o      (chunk_rev),
    .parity_o   (chunk_par)
  );

  assign base      = 6'(iter_q) << SHIFT;
  assign last_iter = (iter_q == LAST_ITER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOP_IDLE;
      op_q    <= '0;
      shreg_q <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
      found_q <= found_d;
    end
  end

  // enable_i seen in DONE belongs to the retiring op, so DONE only ever returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOP_IDLE: if (bus.enable_i) state_d = BOP_RUN;
      BOP_RUN:  if (last_iter)    state_d = BOP_DONE;
      BOP_DONE: if (bus.ex_ready_i) state_d = BOP_IDLE;
      default:  state_d = BOP_IDLE;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    found_d = found_q;
    if (state_q == BOP_IDLE && bus.enable_i) begin
      op_d    = bus.operator_i;
      shreg_d = bus.operand_i;
      acc_d   = '0;
      iter_d  = '0;
      found_d = 1'b0;
    end else if (state_q == BOP_RUN) begin
      shreg_d = shreg_q >> BITS_PER_CYCLE;
      if (!last_iter) iter_d = iter_q + 1'b1;
      case (op_q)
        BOP_CNT: acc_d = acc_q + 32'(chunk_pop);
        BOP_FF1: if (!found_q && chunk_nz) begin
          acc_d   = 32'(base) + 32'(chunk_low);
          found_d = 1'b1;
        end
        BOP_FL1: if (chunk_nz) begin
          acc_d   = 32'(base) + 32'(chunk_high);
          found_d = 1'b1;
        end
        BOP_REV: acc_d = {acc_q[31-BITS_PER_CYCLE:0], chunk_rev};
        BOP_PAR: acc_d = {acc_q[31:1], acc_q[0] ^ chunk_par};
        default: acc_d = '0;
      endcase
      // A search that never hit a set bit reports 32.
      if (last_iter && (op_q == BOP_FF1 || op_q == BOP_FL1) && !found_d) begin
        acc_d = 32'd32;
      end
    end
  end

  always_comb begin
    bus.ready_o  = 1'b0;
    bus.result_o = '0;
    case (state_q)
      BOP_IDLE: bus.ready_o = !bus.enable_i;
      BOP_DONE: begin
        bus.ready_o  = 1'b1;
        bus.result_o = acc_q;
      end
      default: bus.ready_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_riscv_bitops_seq.sv
// Self-checking bench: four instances (4/2/1/8 bits per cycle) checked against
// a whole-word reference model, fixed vectors and hand-written corner sequences.
module tb_riscv_bitops_seq;
  import riscv_defines::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]       en;
  logic [3:0][2:0]  opv;
  logic [3:0][31:0] opnd;
  logic [3:0]       exr;
  logic [3:0][31:0] res;
  logic [3:0]       rdy;

  int checks = 0;
  int errors = 0;

  function automatic int bpc_of(int g);
    case (g)
      0:       return 4;
      1:       return 2;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    riscv_bitops_seq_if bus ();
    assign bus.enable_i   = en[g];
    assign bus.operator_i = opv[g];
    assign bus.operand_i  = opnd[g];
    assign bus.ex_ready_i = exr[g];
    assign res[g]         = bus.result_o;
    assign rdy[g]         = bus.ready_o;
    riscv_bitops_seq #(.BITS_PER_CYCLE(bpc_of(g))) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  // Whole-word reference: each operation computed directly over all 32 bits.
  function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] x);
    logic [31:0] r;
    r = '0;
    case (op)
      3'd0: r = 32'($countones(x));
      3'd1: begin
        r = 32'd32;
        for (int i = 31; i >= 0; i--) if (x[i]) r = 32'(i);
      end
      3'd2: begin
        r = 32'd32;
        for (int i = 0; i < 32; i++) if (x[i]) r = 32'(i);
      end
      3'd3: for (int i = 0; i < 32; i++) r[i] = x[31-i];
      3'd4: r = {31'b0, ^x};
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Issues one op on instance d with ex_ready_i=1, scrambles the inputs while it
  // runs, and retires it; returns the result and cycles until ready_o.
  task automatic applyStimulus(input int d, input logic [2:0] op, input logic [31:0] x,
                               output logic [31:0] r, output int lat);
    en[d]   = 1'b1;
    opv[d]  = op;
    opnd[d] = x;
    exr[d]  = 1'b1;
    @(posedge clk); @(negedge clk);
    lat     = 1;
    opv[d]  = ~op;
    opnd[d] = ~x;
    while (!rdy[d] && lat < 100) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    r     = res[d];
    en[d] = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] r;
    int          lat;
    logic [2:0]  op;
    logic [31:0] x;

    vecs[0] = '{BOP_FF1, 32'h0000_0100, 32'd8};
    vecs[1] = '{BOP_FF1, 32'h0000_0000, 32'd32};
    vecs[2] = '{BOP_FL1, 32'h8000_0001, 32'd31};
    vecs[3] = '{BOP_FL1, 32'h0000_0000, 32'd32};
    vecs[4] = '{BOP_REV, 32'h0000_0001, 32'h8000_0000};
    vecs[5] = '{BOP_REV, 32'h1234_5678, 32'h1E6A_2C48};
    vecs[6] = '{BOP_PAR, 32'h0000_0007, 32'd1};
    vecs[7] = '{3'b111,  32'hFFFF_FFFF, 32'd0};
    vecs[8] = '{BOP_CNT, 32'h0000_0000, 32'd0};

    en = '0; opv = '0; opnd = '0; exr = '1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checkOutput($sformatf("reset_ready_d%0d", d), 32'(rdy[d]), 32'd1);
      checkOutput($sformatf("reset_result_d%0d", d), res[d], 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, BOP_CNT, 32'hF0F0_0001, r, lat);
    checkOutput("cnt_basic_result", r, 32'd9);
    checkOutput("cnt_basic_latency", 32'(lat), 32'd9);
    checkOutput("cnt_basic_idle_ready", 32'(rdy[0]), 32'd1);
    checkOutput("cnt_basic_idle_result", res[0], 32'd0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, vecs[i].op, vecs[i].x, r, lat);
      checkOutput($sformatf("vec%0d_result", i), r, vecs[i].exp);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
    end

    // Stall in DONE: result must hold while inputs wander.
    en[0] = 1'b1; opv[0] = BOP_CNT; opnd[0] = 32'hFFFF_FFFF; exr[0] = 1'b0;
    lat = 0;
    @(posedge clk); @(negedge clk); lat++;
    while (!rdy[0] && lat < 100) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    checkOutput("stall_latency", 32'(lat), 32'd9);
    checkOutput("stall_result", res[0], 32'd32);
    for (int k = 0; k < 3; k++) begin
      opnd[0] = $urandom;
      opv[0]  = BOP_REV;
      @(posedge clk); @(negedge clk);
      checkOutput($sformatf("stall_hold_ready_%0d", k), 32'(rdy[0]), 32'd1);
      checkOutput($sformatf("stall_hold_result_%0d", k), res[0], 32'd32);
    end
    exr[0] = 1'b1; en[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("stall_release_ready", 32'(rdy[0]), 32'd1);
    checkOutput("stall_release_result", res[0], 32'd0);

    // Asynchronous reset at RUN cycle 4, then a clean op.
    en[0] = 1'b1; opv[0] = BOP_CNT; opnd[0] = 32'hFFFF_FFFF;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    checkOutput("midrun_busy", 32'(rdy[0]), 32'd0);
    en[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_ready", 32'(rdy[0]), 32'd1);
    checkOutput("midrun_reset_result", res[0], 32'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("midrun_reset_hold_ready", 32'(rdy[0]), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, BOP_CNT, 32'h0000_0003, r, lat);
    checkOutput("after_reset_result", r, 32'd2);
    checkOutput("after_reset_latency", 32'(lat), 32'd9);

    for (int d = 1; d < 4; d++) begin
      applyStimulus(d, BOP_FL1, 32'h0001_0000, r, lat);
      checkOutput($sformatf("sweep_fl1_result_d%0d", d), r, 32'd16);
      checkOutput($sformatf("sweep_fl1_latency_d%0d", d), 32'(lat), 32'(32 / bpc_of(d) + 1));
      applyStimulus(d, 3'b111, 32'h0001_0000, r, lat);
      checkOutput($sformatf("sweep_unused_result_d%0d", d), r, 32'd0);
      checkOutput($sformatf("sweep_unused_latency_d%0d", d), 32'(lat), 32'(32 / bpc_of(d) + 1));
    end

    // Random ops against the reference; masked operands exercise sparse bit patterns.
    for (int d = 0; d < 4; d++) begin
      for (int n = 0; n < 15; n++) begin
        op = 3'($urandom_range(0, 7));
        x  = $urandom;
        if (n % 3 == 1) x = x & (32'h1 << $urandom_range(0, 31));
        if (n % 3 == 2) x = x & $urandom & $urandom;
        applyStimulus(d, op, x, r, lat);
        checkOutput($sformatf("rand_d%0d_n%0d_op%0d_x%08h", d, n, op, x), r, ref_model(op, x));
        checkOutput($sformatf("rand_lat_d%0d_n%0d", d, n), 32'(lat), 32'(32 / bpc_of(d) + 1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
